// File: rtl/pcm_fifo_reader.sv
// Consumer side of the PCM audio FIFO: paces frame fetches from the sample strobe,
// assembles 8/16-bit mono/stereo frames into signed 16-bit samples and applies volume.
module pcm_fifo_reader (
   input  logic        clk,
   input  logic        rst,
   input  logic        next_sample,
   input  logic [7:0]  rate,
   input  logic        mode_16bit,
   input  logic        mode_stereo,
   input  logic [3:0]  volume,
   input  logic [7:0]  fifo_rddata,
   input  logic        fifo_empty,
   output logic        fifo_rd_en,
   output logic [15:0] left_sample,
   output logic [15:0] right_sample,
   output logic        sample_valid,
   output logic        underrun
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUTPUT} state_t;

   state_t             state;
   logic [6:0]         acc;
   logic [7:0]         rate_eff;
   logic [7:0]         sum;
   logic [1:0]         idx;
   logic [1:0]         last;
   logic               m16;
   logic               mst;
   logic [3:0]         vol;
   logic [7:0]         b0, b1, b2;
   logic [7:0]         f0, f1, f2, f3;
   logic [15:0]        raw_l, raw_r;
   logic [4:0]         gain;
   logic signed [21:0] prod_l, prod_r;

   assign rate_eff = (rate > 8'd128) ? 8'd128 : rate;
   assign sum      = {1'b0, acc} + rate_eff;

   // FIFO handshake: fifo_rd_en pops one byte at the clock edge, and that byte is
   // presented on fifo_rddata throughout the following cycle. Never read when empty.
   assign fifo_rd_en = (state == S_FETCH) && !fifo_empty && !rst;

   // During DRAIN the last byte of the frame is still on fifo_rddata, so it is used
   // directly instead of spending a cycle storing it.
   always_comb begin
      f0    = (last == 2'd0) ? fifo_rddata : b0;
      f1    = (last == 2'd1) ? fifo_rddata : b1;
      f2    = (last == 2'd2) ? fifo_rddata : b2;
      f3    = fifo_rddata;
      raw_l = m16 ? {f1, f0} : {f0, 8'h00};
      if (!mst)
         raw_r = raw_l;
      else if (m16)
         raw_r = {f3, f2};
      else
         raw_r = {f1, 8'h00};
      gain   = (vol == 4'd0) ? 5'd0 : ({1'b0, vol} + 5'd1);
      prod_l = 22'($signed(raw_l)) * 22'($signed({1'b0, gain}));
      prod_r = 22'($signed(raw_r)) * 22'($signed({1'b0, gain}));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         acc          <= 7'd0;
         idx          <= 2'd0;
         last         <= 2'd0;
         m16          <= 1'b0;
         mst          <= 1'b0;
         vol          <= 4'd0;
         b0           <= 8'd0;
         b1           <= 8'd0;
         b2           <= 8'd0;
         left_sample  <= 16'd0;
         right_sample <= 16'd0;
         sample_valid <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         underrun     <= 1'b0;
         if (next_sample)
            acc <= sum[6:0];
         case (state)
            S_IDLE: begin
               if (next_sample && sum[7]) begin
                  m16   <= mode_16bit;
                  mst   <= mode_stereo;
                  vol   <= volume;
                  // Index of the final byte: 0, 1, 1 or 3 for 8m, 8s, 16m, 16s.
                  last  <= {mode_16bit & mode_stereo, mode_16bit | mode_stereo};
                  idx   <= 2'd0;
                  state <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (fifo_empty) begin
                  underrun <= 1'b1;
                  state    <= S_IDLE;
               end else begin
                  case (idx)
                     2'd1:    b0 <= fifo_rddata;
                     2'd2:    b1 <= fifo_rddata;
                     2'd3:    b2 <= fifo_rddata;
                     default: ;
                  endcase
                  if (idx == last)
                     state <= S_DRAIN;
                  else
                     idx <= idx + 2'd1;
               end
            end
            S_DRAIN: begin
               left_sample  <= prod_l[19:4];
               right_sample <= prod_r[19:4];
               sample_valid <= 1'b1;
               state        <= S_OUTPUT;
            end
            S_OUTPUT: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pcm_fifo_reader.sv
// Directed bench for pcm_fifo_reader with a byte-queue FIFO model; each task
// drives one scenario and checks cycle traces and sample values inline.
module tb_pcm_fifo_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        next_sample;
   logic [7:0]  rate;
   logic        mode_16bit;
   logic        mode_stereo;
   logic [3:0]  volume;
   logic [7:0]  fifo_rddata;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [15:0] left_sample;
   logic [15:0] right_sample;
   logic        sample_valid;
   logic        underrun;

   int checks = 0;
   int errors = 0;

   logic [7:0] fifo_q[$];
   int         push_cnt = 0;
   int         pop_cnt  = 0;

   always #5 clk = ~clk;

   pcm_fifo_reader dut (
      .clk          (clk),
      .rst          (rst),
      .next_sample  (next_sample),
      .rate         (rate),
      .mode_16bit   (mode_16bit),
      .mode_stereo  (mode_stereo),
      .volume       (volume),
      .fifo_rddata  (fifo_rddata),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .left_sample  (left_sample),
      .right_sample (right_sample),
      .sample_valid (sample_valid),
      .underrun     (underrun)
   );

   // FIFO model: pop on rd_en, data visible the following cycle.
   assign fifo_empty = (push_cnt == pop_cnt);
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         if (fifo_q.size() > 0)
            fifo_rddata <= fifo_q.pop_front();
         pop_cnt <= pop_cnt + 1;
      end
   end

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      push_cnt = push_cnt + 1;
   endtask

   task automatic flush();
      while (fifo_q.size() > 0) begin
         void'(fifo_q.pop_front());
         push_cnt = push_cnt - 1;
      end
   endtask

   task automatic setup(input logic m16, input logic mst, input logic [3:0] vol, input logic [7:0] r);
      @(negedge clk);
      mode_16bit  = m16;
      mode_stereo = mst;
      volume      = vol;
      rate        = r;
   endtask

   // Bit i of each trace is the signal value in cycle T+i, T being the strobe cycle.
   task automatic trace(output logic [11:0] rd_tr, output logic [11:0] vld_tr, output logic [11:0] und_tr);
      rd_tr  = '0;
      vld_tr = '0;
      und_tr = '0;
      @(negedge clk);
      next_sample = 1'b1;
      #1;
      rd_tr[0]  = fifo_rd_en;
      vld_tr[0] = sample_valid;
      und_tr[0] = underrun;
      for (int i = 1; i < 12; i++) begin
         @(negedge clk);
         next_sample = 1'b0;
         #1;
         rd_tr[i]  = fifo_rd_en;
         vld_tr[i] = sample_valid;
         und_tr[i] = underrun;
      end
   endtask

   // Issues n strobes 10 cycles apart; counts frame attempts (valid or underrun pulses).
   task automatic pace(input int n, output int fetches);
      fetches = 0;
      for (int s = 0; s < n; s++) begin
         @(negedge clk);
         next_sample = 1'b1;
         for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            next_sample = 1'b0;
            #1;
            if (sample_valid || underrun)
               fetches++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      next_sample = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (left_sample !== 16'h0000 || right_sample !== 16'h0000) begin
         errors++;
         $display("FAIL reset_samples: got %h/%h expected 0000/0000", left_sample, right_sample);
      end
      checks++;
      if ({fifo_rd_en, sample_valid, underrun} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000", {fifo_rd_en, sample_valid, underrun});
      end
      // A strobe coinciding with reset must not start a fetch.
      push(8'h55);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      next_sample = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      next_sample = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (fifo_q.size() !== 1) begin
         errors++;
         $display("FAIL rst_beats_strobe: fifo bytes left %0d expected 1", fifo_q.size());
      end
      flush();
   endtask

   task automatic test_8bit_mono();
      logic [11:0] rd, vld, und;
      setup(1'b0, 1'b0, 4'd15, 8'd128);
      push(8'h40);
      trace(rd, vld, und);
      checks++;
      if (rd !== 12'h002) begin
         errors++;
         $display("FAIL m8_rd_trace: got %h expected %h", rd, 12'h002);
      end
      checks++;
      if (vld !== 12'h008 || und !== 12'h000) begin
         errors++;
         $display("FAIL m8_valid_trace: got %h/%h expected 008/000", vld, und);
      end
      checks++;
      if (left_sample !== 16'h4000 || right_sample !== 16'h4000) begin
         errors++;
         $display("FAIL m8_samples: got %h/%h expected 4000/4000", left_sample, right_sample);
      end
   endtask

   task automatic test_8bit_stereo();
      logic [11:0] rd, vld, und;
      setup(1'b0, 1'b1, 4'd15, 8'd128);
      push(8'hC0);
      push(8'h12);
      trace(rd, vld, und);
      checks++;
      if (rd !== 12'h006 || vld !== 12'h010) begin
         errors++;
         $display("FAIL s8_trace: got %h/%h expected 006/010", rd, vld);
      end
      checks++;
      if (left_sample !== 16'hC000 || right_sample !== 16'h1200) begin
         errors++;
         $display("FAIL s8_samples: got %h/%h expected c000/1200", left_sample, right_sample);
      end
   endtask

   task automatic test_16bit_stereo();
      logic [11:0] rd, vld, und;
      setup(1'b1, 1'b1, 4'd15, 8'd128);
      push(8'h34);
      push(8'h12);
      push(8'hCD);
      push(8'hAB);
      trace(rd, vld, und);
      checks++;
      if (rd !== 12'h01E) begin
         errors++;
         $display("FAIL s16_rd_trace: got %h expected %h", rd, 12'h01E);
      end
      checks++;
      if (vld !== 12'h040 || und !== 12'h000) begin
         errors++;
         $display("FAIL s16_valid_trace: got %h/%h expected 040/000", vld, und);
      end
      checks++;
      if (left_sample !== 16'h1234 || right_sample !== 16'hABCD) begin
         errors++;
         $display("FAIL s16_samples: got %h/%h expected 1234/abcd", left_sample, right_sample);
      end
   endtask

   task automatic test_rate_pacing();
      int n;
      setup(1'b0, 1'b0, 4'd15, 8'd64);
      for (int i = 0; i < 5; i++) push(8'h10);
      pace(10, n);
      checks++;
      if (n !== 5) begin
         errors++;
         $display("FAIL rate64: got %0d fetches expected 5", n);
      end
      setup(1'b0, 1'b0, 4'd15, 8'd0);
      pace(6, n);
      checks++;
      if (n !== 0) begin
         errors++;
         $display("FAIL rate0: got %0d fetches expected 0", n);
      end
      setup(1'b0, 1'b0, 4'd15, 8'd1);
      push(8'h10);
      pace(127, n);
      checks++;
      if (n !== 0) begin
         errors++;
         $display("FAIL rate1_early: got %0d fetches expected 0", n);
      end
      pace(1, n);
      checks++;
      if (n !== 1) begin
         errors++;
         $display("FAIL rate1_128th: got %0d fetches expected 1", n);
      end
      setup(1'b0, 1'b0, 4'd15, 8'd200);
      for (int i = 0; i < 4; i++) push(8'h10);
      pace(4, n);
      checks++;
      if (n !== 4) begin
         errors++;
         $display("FAIL rate200: got %0d fetches expected 4", n);
      end
   endtask

   task automatic test_volume();
      logic [11:0] rd, vld, und;
      logic [7:0]  lo_tab  [5] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
      logic [7:0]  hi_tab  [5] = '{8'h80, 8'h80, 8'h80, 8'h7F, 8'h7F};
      logic [3:0]  vol_tab [5] = '{4'd7, 4'd15, 4'd0, 4'd15, 4'd7};
      logic [15:0] exp_tab [5] = '{16'hC000, 16'h8000, 16'h0000, 16'h7FFF, 16'h3FFF};
      for (int i = 0; i < 5; i++) begin
         setup(1'b1, 1'b0, vol_tab[i], 8'd128);
         push(lo_tab[i]);
         push(hi_tab[i]);
         trace(rd, vld, und);
         checks++;
         if (left_sample !== exp_tab[i] || right_sample !== exp_tab[i] || vld !== 12'h010) begin
            errors++;
            $display("FAIL volume_%0d: got %h/%h valid %h expected %h/%h valid 010",
                     i, left_sample, right_sample, vld, exp_tab[i], exp_tab[i]);
         end
      end
   endtask

   task automatic test_underrun();
      logic [11:0] rd, vld, und;
      setup(1'b1, 1'b1, 4'd15, 8'd128);
      push(8'h11);
      push(8'h22);
      trace(rd, vld, und);
      checks++;
      if (rd !== 12'h006 || und !== 12'h010 || vld !== 12'h000) begin
         errors++;
         $display("FAIL underrun_partial: got rd %h und %h vld %h expected 006/010/000", rd, und, vld);
      end
      checks++;
      if (left_sample !== 16'h3FFF || right_sample !== 16'h3FFF) begin
         errors++;
         $display("FAIL underrun_hold: got %h/%h expected 3fff/3fff", left_sample, right_sample);
      end
      trace(rd, vld, und);
      checks++;
      if (rd !== 12'h000 || und !== 12'h004 || vld !== 12'h000) begin
         errors++;
         $display("FAIL underrun_empty: got rd %h und %h vld %h expected 000/004/000", rd, und, vld);
      end
   endtask

   task automatic test_reset_mid_fetch();
      logic [11:0] rd, vld, und;
      setup(1'b1, 1'b1, 4'd15, 8'd128);
      for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
      rd  = '0;
      vld = '0;
      und = '0;
      @(negedge clk);
      next_sample = 1'b1;
      #1;
      rd[0] = fifo_rd_en;
      @(negedge clk);
      next_sample = 1'b0;
      #1;
      rd[1] = fifo_rd_en;
      @(negedge clk);
      rst = 1'b1;
      #1;
      rd[2]  = fifo_rd_en;
      vld[2] = sample_valid;
      und[2] = underrun;
      for (int i = 3; i < 12; i++) begin
         @(negedge clk);
         rst = 1'b0;
         #1;
         rd[i]  = fifo_rd_en;
         vld[i] = sample_valid;
         und[i] = underrun;
      end
      checks++;
      if (rd !== 12'h002 || vld !== 12'h000 || und !== 12'h000) begin
         errors++;
         $display("FAIL rst_mid_trace: got rd %h vld %h und %h expected 002/000/000", rd, vld, und);
      end
      checks++;
      if (left_sample !== 16'h0000 || right_sample !== 16'h0000) begin
         errors++;
         $display("FAIL rst_mid_samples: got %h/%h expected 0000/0000", left_sample, right_sample);
      end
      flush();
      push(8'h01);
      push(8'h02);
      push(8'h03);
      push(8'h04);
      trace(rd, vld, und);
      checks++;
      if (rd !== 12'h01E || vld !== 12'h040) begin
         errors++;
         $display("FAIL rst_recover_trace: got %h/%h expected 01e/040", rd, vld);
      end
      checks++;
      if (left_sample !== 16'h0201 || right_sample !== 16'h0403) begin
         errors++;
         $display("FAIL rst_recover_samples: got %h/%h expected 0201/0403", left_sample, right_sample);
      end
   endtask

   initial begin
      rst         = 1'b1;
      next_sample = 1'b0;
      rate        = 8'd128;
      mode_16bit  = 1'b0;
      mode_stereo = 1'b0;
      volume      = 4'd15;
      fifo_rddata = 8'h00;
      test_reset();
      test_8bit_mono();
      test_8bit_stereo();
      test_16bit_stereo();
      test_rate_pacing();
      test_volume();
      test_underrun();
      test_reset_mid_fetch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
